fault_detect_sequencer: RTL and testbench
=========================================

# fault_detect_sequencer

- Drives the exhaustive 3-bit input sequence into a stuck-at fault circuit pair.
- Consumes the pair's fault-free output (F0) and faulty output (F1) and compares them once per vector after a programmable settle time.
- Records which input vectors detect the fault.
- Sits around the stuck-at circuit under test and replaces the free-running stimulus with a self-checking hardware run.

## Interface

Parameters:
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock. One clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a run; honoured only in IDLE or DONE.
- A  output  1  pattern bit 2 (MSB), driven to the circuit under test.
- B  output  1  pattern bit 1.
- C  output  1  pattern bit 0 (LSB).
- F0  input  1  fault-free circuit output.
- F1  input  1  faulty circuit output.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start or reset.
- fault_detected  output  1  at least one vector mismatched in the last run.
- detect_mask  output  8  bit k set when vector {A,B,C}=k mismatched.
- detect_count  output  4  number of mismatching vectors, 0..8.
- first_vector  output  3  lowest vector that mismatched.
- first_valid  output  1  first_vector holds a valid value.

## Operation

- States: IDLE, SETTLE, SAMPLE, DONE. Registers: pattern[2:0], settle counter, result registers. {A,B,C} = pattern, registered.
- IDLE (reset state):
  - pattern = 000.
  - On start, clear detect_mask, detect_count, fault_detected, first_vector and first_valid, set pattern = 000, load the counter, and go to SETTLE.
- SETTLE:
  - Holds pattern for SETTLE_CYCLES cycles.
  - F0 and F1 are ignored; mismatches here never affect results.
  - Then go to SAMPLE.
- SAMPLE: one cycle. mismatch = F0 ^ F1.
  - If mismatch: set detect_mask[pattern] and increment detect_count.
  - If mismatch and first_valid = 0: load first_vector = pattern and set first_valid.
  - fault_detected = OR of detect_mask, kept up to date.
  - If pattern = 111, go to DONE with pattern unchanged. Otherwise increment pattern, reload the counter, and go to SETTLE.
- DONE:
  - done = 1, busy = 0, and results are held stable.
  - On start, behave as start in IDLE (clear results and rerun).
- start in SETTLE or SAMPLE is ignored.
- detect_count saturates naturally at 8; it needs 4 bits and cannot wrap.
- Reset asserted at any time, including mid-run, returns to IDLE immediately with all outputs at reset values.

## Timing

- Reset values: A = B = C = 0, busy = 0, done = 0, fault_detected = 0, detect_mask = 00, detect_count = 0, first_vector = 000, first_valid = 0.
- start sampled high at edge t:
  - busy = 1 and done = 0 from t+1.
  - Vector 000 is applied from t+1.
- Each vector occupies SETTLE_CYCLES + 1 cycles. F0/F1 are sampled on the last cycle of that window.
- Result updates for a vector are visible on the cycle after its SAMPLE cycle.
- Run length: done = 1 exactly 8*(SETTLE_CYCLES+1) cycles after t+1, i.e. 24 cycles for the default SETTLE_CYCLES = 2.
- Final results are valid in the same cycle that done rises.
- F0 and F1 are sampled synchronously. The circuit under test must settle within SETTLE_CYCLES cycles of a pattern change.

## Test plan

1. Reset: hold rst_n low with start toggling. Required: all outputs at reset values. Release reset: state stays IDLE until start.
2. Fault-free run (F1 = F0 for all vectors, SETTLE_CYCLES = 2):
   - done rises 24 cycles after busy.
   - detect_mask = 00, detect_count = 0, fault_detected = 0, first_valid = 0.
   - {A,B,C} steps 000..111, each vector held 3 cycles.
3. Stuck-at-1 model that mismatches only at vectors 011 and 101:
   - detect_mask = 8'b0010_1000, detect_count = 2.
   - first_vector = 011, first_valid = 1, fault_detected = 1.
4. F1 = ~F0 always: detect_mask = FF, detect_count = 8, first_vector = 000.
5. Boundaries:
   - Mismatch glitch driven only during SETTLE cycles: not recorded.
   - start pulsed mid-run: ignored, run length unchanged.
   - rst_n pulsed low at vector 100: all outputs return to reset values immediately.
   - start in DONE: previous results clear at t+1 and a full 24-cycle rerun follows.
6. SETTLE_CYCLES = 1: run completes in 16 cycles, and the results for the scenario-3 model are identical to scenario 3.

Source files
------------

// File: rtl/fault_detect_sequencer.sv
// Self-checking stimulus sequencer for a stuck-at fault circuit pair: steps {A,B,C}
// through 000..111, samples F0^F1 after a settle window and records detecting vectors.
module fault_detect_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F0,
  input  logic       F1,
  output logic       busy,
  output logic       done,
  output logic       fault_detected,
  output logic [7:0] detect_mask,
  output logic [3:0] detect_count,
  output logic [2:0] first_vector,
  output logic       first_valid,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter runs LOAD..0 so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] pattern;
  logic [3:0] cnt;
  logic       run_go;
  logic       mismatch;

  assign run_go   = ((state == IDLE) || (state == DONE)) && start;
  assign mismatch = F0 ^ F1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETTLE;
      SETTLE:     if (cnt == 4'd0) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (pattern == 3'b111) ? DONE : SETTLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SETTLE) || (state == SAMPLE);
    done      = (state == DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern        <= 3'd0;
      cnt            <= 4'd0;
      detect_mask    <= 8'd0;
      detect_count   <= 4'd0;
      fault_detected <= 1'b0;
      first_vector   <= 3'd0;
      first_valid    <= 1'b0;
    end else if (run_go) begin
      pattern        <= 3'd0;
      cnt            <= CNT_LOAD;
      detect_mask    <= 8'd0;
      detect_count   <= 4'd0;
      fault_detected <= 1'b0;
      first_vector   <= 3'd0;
      first_valid    <= 1'b0;
    end else if (state == SETTLE) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        detect_mask[pattern] <= 1'b1;
        detect_count         <= detect_count + 4'd1;
        fault_detected       <= 1'b1;
        if (!first_valid) begin
          first_vector <= pattern;
          first_valid  <= 1'b1;
        end
      end
      // The last vector stays on the pins through DONE.
      if (pattern != 3'b111) begin
        pattern <= pattern + 3'd1;
        cnt     <= CNT_LOAD;
      end
    end
  end

  assign {A, B, C} = pattern;

endmodule

// File: tb/tb_fault_detect_sequencer.sv
// Bench for fault_detect_sequencer: a behavioural fault-pair model feeds F0/F1, expected
// result words are queued at start and compared when done rises.
module tb_fault_detect_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_s  [2];
  logic       f0_s     [2];
  logic       f1_s     [2];
  logic       glitch_s [2];
  int         mode_s   [2];
  logic [2:0] abc_s    [2];
  logic [1:0] bd_s     [2];  // {busy, done}
  logic [16:0] res_s   [2];  // {fault_detected, mask, count, first_vector, first_valid}
  logic [1:0] sd_s     [2];

  logic a0, b0, c0, busy0, done0, fd0, fv0;
  logic [7:0] mask0;
  logic [3:0] cnt0;
  logic [2:0] first0;
  logic [1:0] sd0;
  logic a1, b1, c1, busy1, done1, fd1, fv1;
  logic [7:0] mask1;
  logic [3:0] cnt1;
  logic [2:0] first1;
  logic [1:0] sd1;

  logic [16:0] exp_q[$];
  int checks;
  int failures;

  fault_detect_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .A(a0), .B(b0), .C(c0), .F0(f0_s[0]), .F1(f1_s[0]),
    .busy(busy0), .done(done0), .fault_detected(fd0),
    .detect_mask(mask0), .detect_count(cnt0),
    .first_vector(first0), .first_valid(fv0), .state_dbg(sd0)
  );

  fault_detect_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .A(a1), .B(b1), .C(c1), .F0(f0_s[1]), .F1(f1_s[1]),
    .busy(busy1), .done(done1), .fault_detected(fd1),
    .detect_mask(mask1), .detect_count(cnt1),
    .first_vector(first1), .first_valid(fv1), .state_dbg(sd1)
  );

  assign abc_s[0] = {a0, b0, c0};
  assign abc_s[1] = {a1, b1, c1};
  assign bd_s[0]  = {busy0, done0};
  assign bd_s[1]  = {busy1, done1};
  assign res_s[0] = {fd0, mask0, cnt0, first0, fv0};
  assign res_s[1] = {fd1, mask1, cnt1, first1, fv1};
  assign sd_s[0]  = sd0;
  assign sd_s[1]  = sd1;

  // Fault models: 0 none, 1 stuck-at hitting 011/101, 2 always inverted, 3 settle-only glitch.
  function automatic logic fault_bit(input int m, input logic [2:0] v, input logic g);
    case (m)
      1:       return (v == 3'd3) || (v == 3'd5);
      2:       return 1'b1;
      3:       return g;
      default: return 1'b0;
    endcase
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_cut
    assign f0_s[i] = ^abc_s[i];
    assign f1_s[i] = f0_s[i] ^ fault_bit(mode_s[i], abc_s[i], glitch_s[i]);
  end

  function automatic logic [16:0] model_result(input int m);
    logic [7:0] mask;
    logic [3:0] cnt;
    logic [2:0] fv;
    logic       fval;
    mask = 8'd0; cnt = 4'd0; fv = 3'd0; fval = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (fault_bit(m, 3'(v), 1'b0)) begin
        mask[v] = 1'b1;
        cnt     = cnt + 4'd1;
        if (!fval) begin
          fv   = 3'(v);
          fval = 1'b1;
        end
      end
    end
    return {|mask, mask, cnt, fv, fval};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int w, input int s, input int m, input bit mid_start);
    logic [16:0] exp;
    mode_s[w]   = m;
    glitch_s[w] = 1'b0;
    exp_q.push_back(model_result(m));
    @(negedge clk); start_s[w] = 1'b1;
    @(negedge clk); start_s[w] = 1'b0;
    for (int k = 0; k < 8 * (s + 1); k++) begin
      check("run_busy", 32'(bd_s[w]), 32'b10);
      check("run_abc", 32'(abc_s[w]), 32'(k / (s + 1)));
      if (k == 0) check("run_cleared", 32'(res_s[w]), 32'd0);
      glitch_s[w] = ((k % (s + 1)) != s);
      start_s[w]  = mid_start && (k == 5);
      @(negedge clk);
    end
    start_s[w]  = 1'b0;
    glitch_s[w] = 1'b0;
    check("run_done", 32'(bd_s[w]), 32'b01);
    check("done_abc", 32'(abc_s[w]), 32'd7);
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check("result", 32'(res_s[w]), 32'(exp));
      @(negedge clk);
      check("hold_done", 32'(bd_s[w]), 32'b01);
      check("hold_result", 32'(res_s[w]), 32'(exp));
    end
  endtask

  task automatic reset_at_vector4(input int s);
    mode_s[0] = 2;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    repeat (4 * (s + 1) + 1) @(negedge clk);
    check("pre_rst_abc", 32'(abc_s[0]), 32'd4);
    check("pre_rst_count", 32'(res_s[0][7:4]), 32'd4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({abc_s[0], bd_s[0], res_s[0]}), 32'd0);
    check("mid_rst_state", 32'(sd_s[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mode_s[0] = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      glitch_s[i] = 1'b0;
      mode_s[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_s[0] = k[0];
      start_s[1] = k[0];
      check("rst_outs0", 32'({abc_s[0], bd_s[0], res_s[0]}), 32'd0);
      check("rst_outs1", 32'({abc_s[1], bd_s[1], res_s[1]}), 32'd0);
    end
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_state0", 32'({sd_s[0], bd_s[0]}), 32'd0);
    check("idle_state1", 32'({sd_s[1], bd_s[1]}), 32'd0);

    run(0, 2, 0, 1'b0);
    run(0, 2, 1, 1'b0);
    run(0, 2, 2, 1'b0);
    run(0, 2, 3, 1'b1);
    run(0, 2, 1, 1'b0);
    reset_at_vector4(2);
    run(0, 2, 2, 1'b0);
    run(1, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
